// File: rtl/card_pkg.sv
// card_pkg: dealing-mode encodings, scripted deck ROM and card-value helpers
package card_pkg;
  typedef enum logic [2:0] {
    MODE_RANDOM = 3'b000,
    MODE_SCRIPT = 3'b001,
    MODE_TWENTY = 3'b010,
    MODE_BJ     = 3'b011,
    MODE_SPLIT  = 3'b100
  } mode_t;
  // entry 0 sits in the low nibble: 10,1, 10,7, 5,6, 9,2, 10,10, 3,4, 8,8, 1,1
  localparam logic [63:0] S1 = {4'd1, 4'd1, 4'd8, 4'd8, 4'd4, 4'd3, 4'd10, 4'd10,
                                4'd2, 4'd9, 4'd6, 4'd5, 4'd7, 4'd10, 4'd1, 4'd10};
  function automatic logic [3:0] s1_card(input logic [3:0] idx);
    return S1[{idx, 2'b00} +: 4];
  endfunction
  function automatic logic [3:0] mod13(input logic [3:0] n);
    return n >= 4'd13 ? n - 4'd13 : n;
  endfunction
  function automatic logic [3:0] rank_value(input logic [3:0] rank);
    return rank > 4'd10 ? 4'd10 : rank;
  endfunction
  function automatic logic [3:0] rand_card(input logic [3:0] n);
    return rank_value(mod13(n) + 4'd1);
  endfunction
endpackage

// File: rtl/card_lfsr.sv
// card_lfsr: free-running 16-bit Fibonacci LFSR, x^16+x^14+x^13+x^11+1
//   clk, reset (async, active-high) -> o_low: low byte of the current state
module card_lfsr #(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic       clk,
  input  logic       reset,
  output logic [7:0] o_low
);
  logic [15:0] r_state;
  always_ff @(posedge clk or posedge reset)
    if (reset) r_state <= SEED;
    else       r_state <= {r_state[14:0], r_state[15] ^ r_state[13] ^ r_state[12] ^ r_state[10]};
  assign o_low = r_state[7:0];
endmodule

// File: rtl/card_generation.sv
// card_generation: two-card source for the blackjack controller, random or scripted decks
//   clk, reset (async, active-high), on (draw request), test (mode)
//   -> card1_out, card2_out: registered cards of the latest draw, 0 before any draw
module card_generation
  import card_pkg::*;
#(
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       on,
  input  logic [2:0] test,
  output logic [3:0] card1_out,
  output logic [3:0] card2_out
);
  logic [7:0] w_lfsr;
  logic [3:0] w_ptr, w_c1, w_c2;
  logic [3:0] r_card1, r_card2, r_ptr;
  logic [2:0] r_last_test;
  card_lfsr #(.SEED(LFSR_SEED)) u_lfsr (.clk(clk), .reset(reset), .o_low(w_lfsr));
  // a mode change restarts the deck on the very edge it is seen
  assign w_ptr = (test != r_last_test) ? 4'd0 : r_ptr;
  always_comb begin
    w_c1 = test == MODE_SCRIPT ? s1_card(w_ptr) :
           test == MODE_TWENTY ? 4'd10 :
           test == MODE_BJ     ? 4'd1  :
           test == MODE_SPLIT  ? 4'd8  : rand_card(w_lfsr[3:0]);
    w_c2 = test == MODE_SCRIPT ? s1_card({w_ptr[3:1], 1'b1}) :
           test == MODE_TWENTY ? 4'd10 :
           test == MODE_BJ     ? 4'd10 :
           test == MODE_SPLIT  ? 4'd8  : rand_card(w_lfsr[7:4]);
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_card1     <= 4'd0;
      r_card2     <= 4'd0;
      r_ptr       <= 4'd0;
      r_last_test <= test;
    end else begin
      r_last_test <= test;
      r_ptr       <= (on && test == MODE_SCRIPT) ? w_ptr + 4'd2 : w_ptr;
      if (on) begin
        r_card1 <= w_c1;
        r_card2 <= w_c2;
      end
    end
  assign card1_out = r_card1;
  assign card2_out = r_card2;
endmodule

// File: tb/tb_card_generation.sv
// tb_card_generation: self-checking bench for card_generation
module tb_card_generation;
  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       on = 1'b0;
  logic [2:0] test = 3'b001;
  logic [3:0] card1_out, card2_out;
  int runs = 0;
  int fails = 0;
  int deck [16] = '{10, 1, 10, 7, 5, 6, 9, 2, 10, 10, 3, 4, 8, 8, 1, 1};
  int gaps [1000];
  int r1 [1000];
  int r2 [1000];
  card_generation dut (.clk(clk), .reset(reset), .on(on), .test(test),
                       .card1_out(card1_out), .card2_out(card2_out));
  always #5 clk = ~clk;
  task automatic do_reset(input logic [2:0] mode);
    @(negedge clk);
    test = mode;
    on = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask
  task automatic pulse();
    on = 1'b1;
    @(negedge clk);
    on = 1'b0;
  endtask
  task automatic expect_pair(input string name, input int e1, input int e2);
    runs++;
    if (card1_out !== 4'(e1) || card2_out !== 4'(e2)) begin
      fails++;
      $display("FAIL %s: got (%0d,%0d) expected (%0d,%0d)", name, card1_out, card2_out, e1, e2);
    end
  endtask
  task automatic test_reset();
    do_reset(3'b001);
    pulse();
    expect_pair("pre_reset_draw", 10, 1);
    #3 reset = 1'b1;
    #1 expect_pair("reset_immediate", 0, 0);
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    expect_pair("post_reset_idle", 0, 0);
  endtask
  task automatic test_script();
    int p = 0;
    do_reset(3'b001);
    for (int i = 0; i < 9; i++) begin
      pulse();
      expect_pair($sformatf("script_%0d", i), deck[p], deck[p + 1]);
      p = (p + 2) % 16;
      repeat (2) @(negedge clk);
      expect_pair($sformatf("script_hold_%0d", i), deck[(p + 14) % 16], deck[(p + 15) % 16]);
    end
  endtask
  task automatic test_fixed();
    logic [2:0] modes [3] = '{3'b010, 3'b011, 3'b100};
    int e1 [3] = '{10, 1, 8};
    int e2 [3] = '{10, 10, 8};
    for (int m = 0; m < 3; m++) begin
      test = modes[m];
      @(negedge clk);
      for (int i = 0; i < 5; i++) begin
        pulse();
        expect_pair($sformatf("fixed_%0d_%0d", modes[m], i), e1[m], e2[m]);
      end
    end
  endtask
  task automatic test_switch();
    test = 3'b001;
    @(negedge clk);
    pulse();
    expect_pair("switch_a", 10, 1);
    pulse();
    expect_pair("switch_b", 10, 7);
    test = 3'b010;
    repeat (2) @(negedge clk);
    expect_pair("switch_no_clear", 10, 7);
    test = 3'b001;
    @(negedge clk);
    pulse();
    expect_pair("switch_ptr_cleared", 10, 1);
    test = 3'b011;
    pulse();
    expect_pair("switch_same_edge", 1, 10);
  endtask
  task automatic test_held();
    test = 3'b001;
    on = 1'b1;
    @(negedge clk);
    expect_pair("held_0", 10, 1);
    @(negedge clk);
    expect_pair("held_1", 10, 7);
    @(negedge clk);
    on = 1'b0;
    expect_pair("held_2", 5, 6);
    repeat (2) @(negedge clk);
    expect_pair("held_stop", 5, 6);
  endtask
  task automatic test_random();
    int tens = 0;
    int bad = 0;
    int diff = 0;
    bit seen [11];
    int distinct = 0;
    for (int i = 0; i < 1000; i++) gaps[i] = $urandom_range(0, 3);
    do_reset(3'b000);
    for (int i = 0; i < 1000; i++) begin
      repeat (gaps[i]) @(negedge clk);
      pulse();
      r1[i] = int'(card1_out);
      r2[i] = int'(card2_out);
      runs++;
      if (r1[i] < 1 || r1[i] > 10 || r2[i] < 1 || r2[i] > 10) begin
        fails++;
        bad++;
        if (bad < 5) $display("FAIL random_range_%0d: got (%0d,%0d) expected 1..10", i, r1[i], r2[i]);
      end else begin
        seen[r1[i]] = 1'b1;
        seen[r2[i]] = 1'b1;
      end
      tens += (r1[i] == 10) + (r2[i] == 10);
    end
    // nibble 9..12 maps to 10, so roughly a quarter to 4/13 of cards
    runs++;
    if (tens < 400 || tens > 720) begin
      fails++;
      $display("FAIL random_tens_freq: got %0d of 2000 expected 400..720", tens);
    end
    for (int v = 1; v <= 10; v++) distinct += seen[v];
    runs++;
    if (distinct != 10) begin
      fails++;
      $display("FAIL random_coverage: got %0d distinct values expected 10", distinct);
    end
    do_reset(3'b000);
    for (int i = 0; i < 1000; i++) begin
      repeat (gaps[i]) @(negedge clk);
      pulse();
      if (int'(card1_out) != r1[i] || int'(card2_out) != r2[i]) begin
        diff++;
        if (diff < 5) $display("FAIL random_repeat_%0d: got (%0d,%0d) expected (%0d,%0d)", i, card1_out, card2_out, r1[i], r2[i]);
      end
    end
    runs++;
    if (diff != 0) begin
      fails++;
      $display("FAIL random_reproducible: got %0d differing draws expected 0", diff);
    end
  endtask
  initial begin
    test_reset();
    test_script();
    test_fixed();
    test_switch();
    test_held();
    test_random();
    $display("[TB] %0d tests run, %0d failed", runs, fails);
    $finish;
  end
endmodule
